chip8_sprite_drawer: RTL and testbench

Executes the CHIP-8 DXYN sprite draw for the processor. It fetches N sprite bytes from RAM starting at I and XORs each one into the 64x32 1-bpp VRAM. It reports the VF collision flag. It sits directly upstream of chip8_memory and drives that block's video request port: video_addr/we/valid/data/type in, video_ready/valid and data_out back.

---
 rtl/chip8_pkg.sv | 26 ++
 rtl/chip8_sprite_drawer.sv | 207 ++++++++++++++++++++
 tb/tb_chip8_sprite_drawer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: video memory port encoding, screen geometry and the
// sprite drawer state type.
package chip8_pkg;

   // Target selector on the video request port
   localparam logic VIDEO_MEM_TYPE_RAM   = 1'b0;
   localparam logic VIDEO_MEM_TYPE_VRAM  = 1'b1;
   localparam int unsigned VIDEO_MEM_TYPE_COUNT = 2;

   // 64x32 monochrome display, one bit per pixel, MSB is the leftmost pixel
   localparam int unsigned SCREEN_W       = 64;
   localparam int unsigned SCREEN_H       = 32;
   localparam int unsigned VRAM_ROW_BYTES = 8;

   typedef enum logic [2:0] {
      StIdle,
      StRdSpr,
      StRdL,
      StWrL,
      StRdR,
      StWrR,
      StWait,
      StDone
   } sprite_state_t;

endpackage

// File: rtl/chip8_sprite_drawer.sv
// CHIP-8 DXYN sprite draw engine. Fetches each sprite row from RAM and XORs it into
// one or two VRAM bytes via read-modify-write, accumulating the VF collision flag.
module chip8_sprite_drawer
   import chip8_pkg::*;
#(
   parameter int unsigned CLIP  = 1,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic [7:0]       x_in,
   input  logic [7:0]       y_in,
   input  logic [3:0]       n_in,
   input  logic [11:0]      i_in,
   output logic             busy_out,
   output logic             done_out,
   output logic             collision_out,
   output logic [15:0]      video_addr_out,
   output logic             video_we_out,
   output logic             video_valid_out,
   output logic [WIDTH-1:0] video_data_out,
   output logic             video_type_out,
   input  logic             mem_ready_in,
   input  logic             mem_valid_in,
   input  logic [WIDTH-1:0] mem_data_in
);

   sprite_state_t    state_q, ret_q;
   logic [5:0]       x0_q;
   logic [4:0]       y0_q;
   logic [3:0]       n_q, r_q;
   logic [11:0]      base_q;
   logic [WIDTH-1:0] spr_q, old_q;
   logic             coll_q;

   logic [2:0]         col, sh;
   logic [4:0]         yr;
   logic [5:0]         yr_nxt;
   logic [3:0]         r_nxt;
   logic [11:0]        spr_addr;
   logic [7:0]         idx_l, idx_r;
   logic [2*WIDTH-1:0] spr_shifted;
   logic [WIDTH-1:0]   mask_l, mask_r;
   logic               use_r, last_row;
   sprite_state_t      next_row_st;
   logic               unused_in;

   // Only x mod 64 and y mod 32 matter
   assign unused_in = ^{x_in[7:6], y_in[7:5]};

   // Row address, byte indices and the two masks for the current row
   always_comb begin
      col         = x0_q[5:3];
      sh          = x0_q[2:0];
      yr          = y0_q + 5'(r_q);  // 5-bit sum wraps rows when clipping is off
      r_nxt       = r_q + 4'd1;
      yr_nxt      = {1'b0, y0_q} + {2'b00, r_nxt};
      spr_addr    = base_q + {8'h00, r_q};
      idx_l       = {yr, col};
      idx_r       = {yr, col + 3'd1};  // col 7 wraps to byte 0 of the same row
      // Upper half is the left-byte mask, lower half the bits spilling right
      spr_shifted = {spr_q, {WIDTH{1'b0}}} >> sh;
      mask_l      = spr_shifted[2*WIDTH-1:WIDTH];
      mask_r      = spr_shifted[WIDTH-1:0];
      use_r       = (sh != 3'd0) && !((CLIP != 0) && (col == 3'd7));
      last_row    = (r_nxt == n_q) || ((CLIP != 0) && (yr_nxt >= 6'(SCREEN_H)));
      next_row_st = last_row ? StDone : StRdSpr;
   end

   // Draw sequencer: one outstanding memory request at a time, registered outputs
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q         <= StIdle;
         ret_q           <= StIdle;
         x0_q            <= '0;
         y0_q            <= '0;
         n_q             <= '0;
         r_q             <= '0;
         base_q          <= '0;
         spr_q           <= '0;
         old_q           <= '0;
         coll_q          <= 1'b0;
         busy_out        <= 1'b0;
         done_out        <= 1'b0;
         collision_out   <= 1'b0;
         video_addr_out  <= '0;
         video_we_out    <= 1'b0;
         video_valid_out <= 1'b0;
         video_data_out  <= '0;
         video_type_out  <= VIDEO_MEM_TYPE_RAM;
      end else begin
         done_out <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start_in) begin
                  x0_q          <= x_in[5:0];
                  y0_q          <= y_in[4:0];
                  n_q           <= n_in;
                  base_q        <= i_in;
                  r_q           <= '0;
                  coll_q        <= 1'b0;
                  collision_out <= 1'b0;
                  if (n_in == 4'd0) begin
                     done_out <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     busy_out <= 1'b1;
                     state_q  <= StRdSpr;
                  end
               end
            end
            StRdSpr: begin
               if (!video_valid_out) begin
                  video_valid_out <= 1'b1;
                  video_we_out    <= 1'b0;
                  video_type_out  <= VIDEO_MEM_TYPE_RAM;
                  video_addr_out  <= {4'h0, spr_addr};
               end else if (mem_ready_in) begin
                  video_valid_out <= 1'b0;
                  ret_q           <= StRdL;
                  state_q         <= StWait;
               end
            end
            StRdL: begin
               if (!video_valid_out) begin
                  video_valid_out <= 1'b1;
                  video_we_out    <= 1'b0;
                  video_type_out  <= VIDEO_MEM_TYPE_VRAM;
                  video_addr_out  <= {8'h00, idx_l};
               end else if (mem_ready_in) begin
                  video_valid_out <= 1'b0;
                  ret_q           <= StWrL;
                  state_q         <= StWait;
               end
            end
            StWrL: begin
               if (!video_valid_out) begin
                  video_valid_out <= 1'b1;
                  video_we_out    <= 1'b1;
                  video_type_out  <= VIDEO_MEM_TYPE_VRAM;
                  video_addr_out  <= {8'h00, idx_l};
                  video_data_out  <= old_q ^ mask_l;
                  coll_q          <= coll_q | (|(old_q & mask_l));
               end else if (mem_ready_in) begin
                  video_valid_out <= 1'b0;
                  video_we_out    <= 1'b0;
                  state_q         <= StWait;
                  if (use_r) begin
                     ret_q <= StRdR;
                  end else begin
                     ret_q <= next_row_st;
                     r_q   <= r_nxt;
                  end
               end
            end
            StRdR: begin
               if (!video_valid_out) begin
                  video_valid_out <= 1'b1;
                  video_we_out    <= 1'b0;
                  video_type_out  <= VIDEO_MEM_TYPE_VRAM;
                  video_addr_out  <= {8'h00, idx_r};
               end else if (mem_ready_in) begin
                  video_valid_out <= 1'b0;
                  ret_q           <= StWrR;
                  state_q         <= StWait;
               end
            end
            StWrR: begin
               if (!video_valid_out) begin
                  video_valid_out <= 1'b1;
                  video_we_out    <= 1'b1;
                  video_type_out  <= VIDEO_MEM_TYPE_VRAM;
                  video_addr_out  <= {8'h00, idx_r};
                  video_data_out  <= old_q ^ mask_r;
                  coll_q          <= coll_q | (|(old_q & mask_r));
               end else if (mem_ready_in) begin
                  video_valid_out <= 1'b0;
                  video_we_out    <= 1'b0;
                  ret_q           <= next_row_st;
                  r_q             <= r_nxt;
                  state_q         <= StWait;
               end
            end
            StWait: begin
               if (mem_valid_in) begin
                  if (ret_q == StRdL) begin
                     spr_q <= mem_data_in;
                  end else if ((ret_q == StWrL) || (ret_q == StWrR)) begin
                     old_q <= mem_data_in;
                  end
                  if (ret_q == StDone) begin
                     done_out      <= 1'b1;
                     busy_out      <= 1'b0;
                     collision_out <= coll_q;
                  end
                  state_q <= ret_q;
               end
            end
            // start_in is deliberately not looked at here
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_chip8_sprite_drawer.sv
// Bench for chip8_sprite_drawer: one CLIP=1 and one CLIP=0 instance share stimulus,
// each with its own RAM/VRAM responder, checked against a pixel-level draw model.
module tb_chip8_sprite_drawer;

   localparam int NI     = 2;
   localparam int LOGMAX = 128;

   logic        clk;
   logic        rst, start;
   logic [7:0]  x_v, y_v;
   logic [3:0]  n_v;
   logic [11:0] i_v;

   logic [NI-1:0] busy, done, coll, vvalid, vwe, vtype, mready, mvalid;
   logic [15:0]   vaddr [NI];
   logic [7:0]    vdata [NI];
   logic [7:0]    mdata [NI];

   logic [7:0]  ram [4096];
   logic [7:0]  init_vram [256];
   logic [7:0]  vram [NI][256];
   logic [7:0]  exp_vram [NI][256];
   logic [25:0] log_r [NI][LOGMAX];
   logic [25:0] exp_r [NI][LOGMAX];
   int          log_n [NI];
   int          exp_n [NI];
   bit          exp_coll [NI];
   int          done_cnt [NI];
   int          overlap [NI];
   int          rsp_cnt [NI];
   logic [7:0]  rsp_data [NI];

   logic force_stall, rnd_ready;
   int   n_checks, n_fail;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      chip8_sprite_drawer #(
         .CLIP  ((g == 0) ? 1 : 0),
         .WIDTH (8)
      ) u_dut (
         .clk_in          (clk),
         .rst_in          (rst),
         .start_in        (start),
         .x_in            (x_v),
         .y_in            (y_v),
         .n_in            (n_v),
         .i_in            (i_v),
         .busy_out        (busy[g]),
         .done_out        (done[g]),
         .collision_out   (coll[g]),
         .video_addr_out  (vaddr[g]),
         .video_we_out    (vwe[g]),
         .video_valid_out (vvalid[g]),
         .video_data_out  (vdata[g]),
         .video_type_out  (vtype[g]),
         .mem_ready_in    (mready[g]),
         .mem_valid_in    (mvalid[g]),
         .mem_data_in     (mdata[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [29:0] outs(input int g);
      return {busy[g], done[g], coll[g], vvalid[g], vwe[g], vtype[g], vaddr[g], vdata[g]};
   endfunction

   // Memory responder: decides ready for the coming edge, logs accepted requests and
   // completes each one 1..3 cycles later.
   initial begin
      mready = '0;
      mvalid = '0;
      for (int g = 0; g < NI; g++) begin
         mdata[g]   = 8'h00;
         rsp_cnt[g] = 0;
      end
      forever begin
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            mvalid[g] = 1'b0;
            if (rst) begin
               rsp_cnt[g] = 0;
            end else if (rsp_cnt[g] > 0) begin
               rsp_cnt[g]--;
               if (rsp_cnt[g] == 0) begin
                  mvalid[g] = 1'b1;
                  mdata[g]  = rsp_data[g];
               end
            end
            if (force_stall) mready[g] = 1'b0;
            else if (rnd_ready) mready[g] = ($urandom_range(0, 3) != 0);
            else mready[g] = 1'b1;
            if (done[g]) done_cnt[g]++;
            if (vvalid[g] && mready[g] && !rst) begin
               if (rsp_cnt[g] > 0 || mvalid[g]) overlap[g]++;
               if (log_n[g] < LOGMAX)
                  log_r[g][log_n[g]] = {vtype[g], vwe[g], vaddr[g], vwe[g] ? vdata[g] : 8'h00};
               log_n[g]++;
               rsp_data[g] = 8'h00;
               if (vwe[g]) begin
                  if (vtype[g]) vram[g][vaddr[g][7:0]] = vdata[g];
               end else begin
                  rsp_data[g] = vtype[g] ? vram[g][vaddr[g][7:0]] : ram[vaddr[g][11:0]];
               end
               rsp_cnt[g] = $urandom_range(1, 3);
            end
         end
      end
   end

   task automatic push_exp(input int g, input logic [25:0] e);
      if (exp_n[g] < LOGMAX) exp_r[g][exp_n[g]] = e;
      exp_n[g]++;
   endtask

   // Reference draw: place each lit sprite pixel on the screen, then list the bytes
   // the row touches (left, then right) as read + write pairs.
   task automatic model(input int g, input bit clip, input int x, input int y, input int n,
                        input int base);
      int x0, y0, yr, sa, px, k, idx;
      logic [7:0] spr, old, m [8];
      bit t [8];
      bit c;
      x0 = x % 64;
      y0 = y % 32;
      c  = 0;
      for (int r = 0; r < n; r++) begin
         yr = y0 + r;
         if (yr > 31) begin
            if (clip) break;
            yr = yr - 32;
         end
         sa  = (base + r) % 4096;
         spr = ram[sa];
         push_exp(g, {1'b0, 1'b0, 16'(sa), 8'h00});
         for (int j = 0; j < 8; j++) begin
            m[j] = 8'h00;
            t[j] = 0;
         end
         t[x0 / 8] = 1;
         if ((x0 % 8 != 0) && ((x0 / 8 < 7) || !clip)) t[(x0 / 8 + 1) % 8] = 1;
         for (int b = 0; b < 8; b++) begin
            if (spr[7-b]) begin
               px = x0 + b;
               if (!(px > 63 && clip)) begin
                  px = px % 64;
                  m[px / 8][7 - (px % 8)] = 1'b1;
               end
            end
         end
         for (int j = 0; j < 2; j++) begin
            k = (x0 / 8 + j) % 8;
            if (t[k]) begin
               idx = yr * 8 + k;
               old = exp_vram[g][idx];
               push_exp(g, {1'b1, 1'b0, 16'(idx), 8'h00});
               push_exp(g, {1'b1, 1'b1, 16'(idx), old ^ m[k]});
               if ((old & m[k]) != 8'h00) c = 1;
               exp_vram[g][idx] = old ^ m[k];
            end
         end
      end
      exp_coll[g] = c;
   endtask

   task automatic prep(input int g, input bit keep);
      if (!keep) begin
         for (int k = 0; k < 256; k++) begin
            vram[g][k]     = init_vram[k];
            exp_vram[g][k] = init_vram[k];
         end
      end
      log_n[g]    = 0;
      exp_n[g]    = 0;
      done_cnt[g] = 0;
      overlap[g]  = 0;
   endtask

   task automatic verify(input int g, input string tag);
      string t;
      int    bad;
      t = $sformatf("%s/clip%0d", tag, (g == 0) ? 1 : 0);
      check_eq({t, "/done_pulses"}, done_cnt[g], 1);
      check_eq({t, "/collision"}, coll[g], exp_coll[g]);
      check_eq({t, "/req_count"}, log_n[g], exp_n[g]);
      check_eq({t, "/overlap"}, overlap[g], 0);
      for (int k = 0; k < log_n[g] && k < exp_n[g] && k < LOGMAX; k++) begin
         if (log_r[g][k] !== exp_r[g][k]) begin
            check_eq($sformatf("%s/req%0d", t, k), log_r[g][k], exp_r[g][k]);
            break;
         end
      end
      bad = 0;
      for (int k = 0; k < 256; k++) if (vram[g][k] !== exp_vram[g][k]) bad++;
      check_eq({t, "/vram_bad_bytes"}, bad, 0);
   endtask

   // Called on a negedge with the DUTs idle; returns on a negedge
   task automatic draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                       input logic [11:0] base, input bit keep, input bit stall,
                       input string tag);
      for (int g = 0; g < NI; g++) begin
         prep(g, keep);
         model(g, g == 0, x, y, n, base);
      end
      x_v   = x;
      y_v   = y;
      n_v   = n;
      i_v   = base;
      if (stall) force_stall = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int g = 0; g < NI; g++) begin
         check_eq($sformatf("%s/g%0d/busy_after_start", tag, g), busy[g], n != 4'd0);
         check_eq($sformatf("%s/g%0d/coll_cleared", tag, g), coll[g], 0);
         if (n == 4'd0) check_eq($sformatf("%s/g%0d/done_next", tag, g), done[g], 1);
      end
      if (stall) begin
         for (int c = 0; c < 20 && vvalid != 2'b11; c++) @(negedge clk);
         for (int k = 0; k < 5; k++) begin
            for (int g = 0; g < NI; g++)
               check_eq($sformatf("%s/g%0d/stall_hold%0d", tag, g, k),
                        {vvalid[g], vwe[g], vtype[g], vaddr[g]},
                        {1'b1, 1'b0, 1'b0, 4'h0, base});
            @(negedge clk);
         end
         @(posedge clk);
         #1 force_stall = 1'b0;
      end
      for (int c = 0; c < 3000 && !(done_cnt[0] > 0 && done_cnt[1] > 0); c++)
         @(negedge clk);
      repeat (4) @(negedge clk);
      for (int g = 0; g < NI; g++) verify(g, tag);
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      start       = 1'b0;
      x_v         = '0;
      y_v         = '0;
      n_v         = '0;
      i_v         = '0;
      force_stall = 1'b0;
      rnd_ready   = 1'b0;
      for (int k = 0; k < 4096; k++) ram[k] = 8'($urandom);
      for (int k = 0; k < 256; k++) init_vram[k] = 8'h00;
      for (int g = 0; g < NI; g++) prep(g, 0);
      repeat (3) @(negedge clk);
      for (int g = 0; g < NI; g++) check_eq($sformatf("reset/g%0d", g), outs(g), 0);
      rst = 1'b0;
      @(negedge clk);

      ram[12'h050] = 8'hF0;
      draw(8'd0, 8'd0, 4'd1, 12'h050, 0, 0, "basic");
      ram[12'h100] = 8'hFF;
      draw(8'd4, 8'd0, 4'd1, 12'h100, 0, 0, "split");
      draw(8'd60, 8'd0, 4'd1, 12'h100, 0, 0, "right_edge");
      ram[12'h180] = 8'hA5;
      draw(8'd8, 8'd5, 4'd1, 12'h180, 0, 0, "twice_first");
      draw(8'd8, 8'd5, 4'd1, 12'h180, 1, 0, "twice_second");
      draw(8'd70, 8'd31, 4'd3, 12'h200, 0, 0, "bottom_edge");
      draw(8'd13, 8'd9, 4'd2, 12'h300, 0, 1, "stall");
      draw(8'd5, 8'd5, 4'd0, 12'h000, 0, 0, "empty");

      // Abort a long draw with reset
      for (int g = 0; g < NI; g++) prep(g, 0);
      x_v   = 8'd3;
      y_v   = 8'd2;
      n_v   = 4'd15;
      i_v   = 12'h400;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int g = 0; g < NI; g++) check_eq($sformatf("abort/g%0d", g), outs(g), 0);
      rst = 1'b0;
      @(negedge clk);

      rnd_ready = 1'b1;
      for (int it = 0; it < 12; it++) begin
         for (int k = 0; k < 256; k++) init_vram[k] = 8'($urandom);
         draw(8'($urandom), 8'($urandom), 4'($urandom), 12'($urandom), 0, 0,
              $sformatf("rand%0d", it));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
